// File: rtl/ym_timers.sv
// YM2151 Timer A / Timer B: prescaled up-counters with reload, sticky overflow
// flags gated by IRQEN, and the CSM key-on pulse driven by Timer A overflow.
module ym_timers (
  input  logic       phiM,
  input  logic       IC_b,
  input  logic [9:0] na,
  input  logic [7:0] nb,
  input  logic       ctrl_wr,
  input  logic [7:0] ctrl,
  output logic       TM_1,
  output logic       TM_2,
  output logic       csm_kon
);

  localparam logic [5:0] PRE_A_LAST = 6'd63;
  localparam logic [9:0] CNT_A_LAST = 10'd1023;
  localparam logic [9:0] PRE_B_LAST = 10'd1023;
  localparam logic [7:0] CNT_B_LAST = 8'd255;

  logic [5:0] pre_a_q, pre_a_d;
  logic [9:0] cnt_a_q, cnt_a_d;
  logic [9:0] pre_b_q, pre_b_d;
  logic [7:0] cnt_b_q, cnt_b_d;

  logic csm_q, csm_d;
  logic irqen_a_q, irqen_a_d;
  logic irqen_b_q, irqen_b_d;
  logic run_a_q, run_a_d;
  logic run_b_q, run_b_d;

  logic tm_1_q, tm_1_d;
  logic tm_2_q, tm_2_d;
  logic csm_kon_q, csm_kon_d;

  logic ovf_a;
  logic ovf_b;

  logic wr_csm, wr_frst_b, wr_frst_a, wr_irqen_b, wr_irqen_a, wr_load_b, wr_load_a;

  assign wr_csm     = ctrl[7];
  assign wr_frst_b  = ctrl[5];
  assign wr_frst_a  = ctrl[4];
  assign wr_irqen_b = ctrl[3];
  assign wr_irqen_a = ctrl[2];
  assign wr_load_b  = ctrl[1];
  assign wr_load_a  = ctrl[0];

  assign ovf_a = run_a_q && (pre_a_q == PRE_A_LAST) && (cnt_a_q == CNT_A_LAST);
  assign ovf_b = run_b_q && (pre_b_q == PRE_B_LAST) && (cnt_b_q == CNT_B_LAST);

  always_comb begin
    csm_d     = csm_q;
    irqen_a_d = irqen_a_q;
    irqen_b_d = irqen_b_q;
    run_a_d   = run_a_q;
    run_b_d   = run_b_q;
    if (ctrl_wr) begin
      csm_d     = wr_csm;
      irqen_a_d = wr_irqen_a;
      irqen_b_d = wr_irqen_b;
      run_a_d   = wr_load_a;
      run_b_d   = wr_load_b;
    end
  end

  // A start edge only happens while stopped, so it never collides with counting.
  always_comb begin
    pre_a_d = pre_a_q;
    cnt_a_d = cnt_a_q;
    if (run_a_q) begin
      pre_a_d = pre_a_q + 6'd1;
      if (pre_a_q == PRE_A_LAST) begin
        if (cnt_a_q == CNT_A_LAST) begin
          cnt_a_d = na;
        end else begin
          cnt_a_d = cnt_a_q + 10'd1;
        end
      end
    end
    if (ctrl_wr && wr_load_a && !run_a_q) begin
      cnt_a_d = na;
      pre_a_d = '0;
    end
  end

  always_comb begin
    pre_b_d = pre_b_q;
    cnt_b_d = cnt_b_q;
    if (run_b_q) begin
      pre_b_d = pre_b_q + 10'd1;
      if (pre_b_q == PRE_B_LAST) begin
        if (cnt_b_q == CNT_B_LAST) begin
          cnt_b_d = nb;
        end else begin
          cnt_b_d = cnt_b_q + 8'd1;
        end
      end
    end
    if (ctrl_wr && wr_load_b && !run_b_q) begin
      cnt_b_d = nb;
      pre_b_d = '0;
    end
  end

  // Set is ORed in after the clear so an overflow beats a same-edge F-reset.
  always_comb begin
    tm_1_d = tm_1_q;
    tm_2_d = tm_2_q;
    if (ctrl_wr && wr_frst_a) begin
      tm_1_d = 1'b0;
    end
    if (ctrl_wr && wr_frst_b) begin
      tm_2_d = 1'b0;
    end
    if (ovf_a && irqen_a_q) begin
      tm_1_d = 1'b1;
    end
    if (ovf_b && irqen_b_q) begin
      tm_2_d = 1'b1;
    end
    csm_kon_d = ovf_a && csm_q;
  end

  always_ff @(posedge phiM or negedge IC_b) begin
    if (!IC_b) begin
      pre_a_q   <= '0;
      cnt_a_q   <= '0;
      pre_b_q   <= '0;
      cnt_b_q   <= '0;
      csm_q     <= 1'b0;
      irqen_a_q <= 1'b0;
      irqen_b_q <= 1'b0;
      run_a_q   <= 1'b0;
      run_b_q   <= 1'b0;
      tm_1_q    <= 1'b0;
      tm_2_q    <= 1'b0;
      csm_kon_q <= 1'b0;
    end else begin
      pre_a_q   <= pre_a_d;
      cnt_a_q   <= cnt_a_d;
      pre_b_q   <= pre_b_d;
      cnt_b_q   <= cnt_b_d;
      csm_q     <= csm_d;
      irqen_a_q <= irqen_a_d;
      irqen_b_q <= irqen_b_d;
      run_a_q   <= run_a_d;
      run_b_q   <= run_b_d;
      tm_1_q    <= tm_1_d;
      tm_2_q    <= tm_2_d;
      csm_kon_q <= csm_kon_d;
    end
  end

  assign TM_1    = tm_1_q;
  assign TM_2    = tm_2_q;
  assign csm_kon = csm_kon_q;

endmodule

// File: tb/tb_ym_timers.sv
// Directed bench for ym_timers: periods, IRQEN gating, set/reset race, CSM,
// stop/restart and asynchronous reset, all against hand-computed edge counts.
module tb_ym_timers;

  logic       phiM;
  logic       IC_b;
  logic [9:0] na;
  logic [7:0] nb;
  logic       ctrl_wr;
  logic [7:0] ctrl;
  logic       TM_1;
  logic       TM_2;
  logic       csm_kon;

  int tests_run;
  int tests_failed;
  int pulses;
  int flag_hits;

  ym_timers dut (
    .phiM    (phiM),
    .IC_b    (IC_b),
    .na      (na),
    .nb      (nb),
    .ctrl_wr (ctrl_wr),
    .ctrl    (ctrl),
    .TM_1    (TM_1),
    .TM_2    (TM_2),
    .csm_kon (csm_kon)
  );

  initial phiM = 1'b0;
  always #5 phiM = ~phiM;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the write is sampled at the next rising edge (E)
  // and the task returns at the falling edge just after E.
  task automatic apply_write(input logic [7:0] value);
    ctrl    = value;
    ctrl_wr = 1'b1;
    @(posedge phiM);
    @(negedge phiM);
    ctrl_wr = 1'b0;
    ctrl    = 8'h00;
  endtask

  // Advance n rising edges, returning at the falling edge after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge phiM);
    @(negedge phiM);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    IC_b    = 1'b0;
    na      = 10'd0;
    nb      = 8'd0;
    ctrl_wr = 1'b0;
    ctrl    = 8'h00;

    repeat (3) @(negedge phiM);
    check_output("reset_tm1", TM_1, 1'b0);
    check_output("reset_tm2", TM_2, 1'b0);
    check_output("reset_csm", csm_kon, 1'b0);
    IC_b = 1'b1;
    step(2);

    // Timer A period 64 with IRQEN A
    na = 10'd1023;
    apply_write(8'h05);
    step(63);
    check_output("a_before_first_ovf", TM_1, 1'b0);
    step(1);
    check_output("a_first_ovf", TM_1, 1'b1);
    check_output("a_no_csm", csm_kon, 1'b0);
    apply_write(8'h15);
    check_output("a_freset_clears", TM_1, 1'b0);
    step(62);
    check_output("a_before_second_ovf", TM_1, 1'b0);
    step(1);
    check_output("a_second_ovf", TM_1, 1'b1);
    apply_write(8'h10);
    check_output("a_stop_and_clear", TM_1, 1'b0);

    // Timer B period 2048
    nb = 8'd254;
    apply_write(8'h0A);
    step(2047);
    check_output("b_before_ovf", TM_2, 1'b0);
    step(1);
    check_output("b_ovf", TM_2, 1'b1);
    check_output("b_tm1_quiet", TM_1, 1'b0);
    apply_write(8'h20);
    check_output("b_freset_clears", TM_2, 1'b0);

    // IRQEN gating with period 256; overflows at E+256k
    na = 10'd1020;
    apply_write(8'h01);
    step(778);
    check_output("irqen_off_no_set", TM_1, 1'b0);
    apply_write(8'h05);
    step(244);
    check_output("irqen_on_before_ovf", TM_1, 1'b0);
    step(1);
    check_output("irqen_on_sets", TM_1, 1'b1);
    apply_write(8'h01);
    step(300);
    check_output("irqen_off_keeps_flag", TM_1, 1'b1);

    // Set-vs-reset race: write at E+1326, overflow at E+1536
    apply_write(8'h15);
    check_output("race_pre_clear", TM_1, 1'b0);
    step(209);
    check_output("race_before_ovf", TM_1, 1'b0);
    apply_write(8'h15);
    check_output("race_set_wins", TM_1, 1'b1);
    apply_write(8'h15);
    check_output("race_late_reset", TM_1, 1'b0);
    apply_write(8'h00);

    // CSM key-on pulse every 64 cycles, no flag without IRQEN
    na = 10'd1023;
    apply_write(8'h81);
    step(63);
    check_output("csm_before_pulse", csm_kon, 1'b0);
    step(1);
    check_output("csm_pulse1", csm_kon, 1'b1);
    step(1);
    check_output("csm_pulse1_width", csm_kon, 1'b0);
    step(62);
    check_output("csm_before_pulse2", csm_kon, 1'b0);
    step(1);
    check_output("csm_pulse2", csm_kon, 1'b1);
    check_output("csm_tm1_quiet", TM_1, 1'b0);
    apply_write(8'h00);
    pulses = 0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (csm_kon) pulses++;
    end
    check_output("csm_stopped", pulses, 0);

    // Stop after 1000 cycles with NA=0: no overflow
    na = 10'd0;
    apply_write(8'h05);
    step(1000);
    apply_write(8'h04);
    step(100);
    check_output("stop_no_ovf", TM_1, 1'b0);

    // Restart A (reload) together with B and CSM; A every 64, B at 1024
    na = 10'd1023;
    nb = 8'd255;
    apply_write(8'h8F);
    step(63);
    check_output("restart_before_ovf", TM_1, 1'b0);
    step(1);
    check_output("restart_ovf", TM_1, 1'b1);
    step(959);
    check_output("both_b_before_ovf", TM_2, 1'b0);
    step(1);
    check_output("both_b_ovf", TM_2, 1'b1);
    check_output("both_csm_pulse", csm_kon, 1'b1);

    // Asynchronous reset between clock edges
    #2;
    IC_b = 1'b0;
    #1;
    check_output("async_tm1", TM_1, 1'b0);
    check_output("async_tm2", TM_2, 1'b0);
    check_output("async_csm", csm_kon, 1'b0);
    step(3);
    check_output("held_tm1", TM_1, 1'b0);
    IC_b = 1'b1;

    flag_hits = 0;
    for (int i = 0; i < 70000; i++) begin
      step(1);
      if (TM_1 || TM_2 || csm_kon) flag_hits++;
    end
    check_output("post_reset_idle", flag_hits, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ym_timers.md
# ym_timers

Timer A / Timer B block for the YM2151 core. Sits directly upstream of the register file: takes the timer values and the timer control byte written through the register file and produces the overflow flags `TM_1` / `TM_2`. The register file reflects those flags in status bits 0/1 and drives `IRQ_b` from them. Also emits the CSM key-on pulse on Timer A overflow.

## Interface

Parameters: none; all widths are fixed by the YM2151 register map.

Ports:
- phiM  in  1  master clock, 3.579545 MHz; the only clock.
- IC_b  in  1  reset; asynchronous, active-low.
- na  in  10  Timer A value NA = {reg 0x10[7:0], reg 0x11[1:0]}; held stable by the register file.
- nb  in  8  Timer B value NB = reg 0x12.
- ctrl_wr  in  1  one-cycle strobe: a data write to reg 0x14 is present on `ctrl` this cycle.
- ctrl  in  8  reg 0x14 data, decoded as follows:
  - [7] CSM
  - [5] F-reset B
  - [4] F-reset A
  - [3] IRQEN B
  - [2] IRQEN A
  - [1] LOAD B
  - [0] LOAD A
  - [6] is ignored.
- TM_1  out  1  Timer A overflow flag, sticky.
- TM_2  out  1  Timer B overflow flag, sticky.
- csm_kon  out  1  one-cycle pulse: key-on all slots (CSM mode).

## Operation

- Internal state:
  - 6-bit prescaler `pre_a` and 10-bit counter `cnt_a`.
  - 10-bit prescaler `pre_b` and 8-bit counter `cnt_b`.
  - Latched control bits `csm`, `irqen_a`, `irqen_b`, `run_a`, `run_b`.
- On `ctrl_wr`:
  - `csm`, `irqen_*` and `run_*` latch from `ctrl`.
  - F-reset bits are pulses and are not stored.
- Timer A start: on `ctrl_wr` with `ctrl[0]=1` while `run_a=0`, set `cnt_a<=na` and `pre_a<=0`.
- Repeated LOAD: writing LOAD A=1 while already running does nothing; there is no reload and no prescaler clear.
- Timer A stop: writing LOAD A=0 sets `run_a<=0`. `cnt_a` and `pre_a` hold their values, but a later start reloads them.
- Timer A counting, each edge while `run_a=1` (and not the start edge):
  - `pre_a` increments, wrapping 63→0.
  - When `pre_a==63`:
    - if `cnt_a==1023`: `cnt_a<=na` and `ovf_a` is raised for that edge;
    - else `cnt_a<=cnt_a+1`.
- Timer B: identical, using `pre_b` (wraps 1023→0), `cnt_b` (terminal count 255) and `nb`.
- Resulting periods:
  - Timer A: 64·(1024−NA) phiM cycles.
  - Timer B: 1024·(256−NB) phiM cycles.
- Value changes: a change of `na`/`nb` while running takes effect at the next reload only.
- Flags:
  - `TM_1` sets on `ovf_a` when `irqen_a=1`. Same rule for `TM_2` with `ovf_b` and `irqen_b`.
  - `ctrl_wr` with F-reset A=1 clears `TM_1`; F-reset B clears `TM_2`.
  - Set wins over a same-edge reset.
  - Clearing IRQEN blocks new sets only; an already-set flag stays set.
  - The IRQEN value used on an edge is the value latched before that edge. A `ctrl_wr` on the overflow edge affects the next overflow only.
- CSM: `csm_kon` is high for exactly the one cycle following an edge with `ovf_a=1` and `csm=1`. It is independent of `irqen_a`. Timer B never drives it.
- Arithmetic: all counters are unsigned and compare against a constant terminal count. There is no subtraction.

## Timing

- Reset (`IC_b=0`, asynchronous): all counters, prescalers and control bits are 0, timers are stopped, and `TM_1=TM_2=csm_kon=0`. Outputs are 0 for as long as `IC_b` is low.
- Reset release: no timer runs until a LOAD write.
- Latency for Timer A: with the start write sampled at edge E, the first overflow is at edge E+64·(1024−NA).
  - `TM_1` is high after that edge, i.e. a registered output with no combinational path from inputs.
  - Subsequent overflows follow every 64·(1024−NA) edges.
- Latency for Timer B: first overflow at E+1024·(256−NB).
- Reset mid-count: counting stops immediately; after release, a fresh LOAD is required.
- Simultaneous start: a write starting A and B on the same edge starts both. Their overflows are independent, and both flags may set on the same edge.
- Stop/start on the same `ctrl_wr`: this is impossible by encoding, since one bit carries both.

## Test plan

- Timer A period: reset; NA=1023, write 0x14=0x05 at edge E.
  - `TM_1` rises after edge E+64, not earlier.
  - F-reset A write (0x15) clears it.
  - Next rise at E+128.
- Timer B period: NB=254, write 0x0A at E.
  - `TM_2` rises after E+2048.
  - `TM_1` stays 0 throughout.
- IRQEN gating: NA=1020, write 0x01 (LOAD A, no IRQEN).
  - Across 3 overflows `TM_1` stays 0.
  - Write 0x05: the next overflow sets `TM_1`.
  - Write 0x01 again: `TM_1` stays 1.
- Set-vs-reset race: issue F-reset A on the exact overflow edge.
  - `TM_1` ends at 1.
  - An F-reset one cycle later ends at 0.
- CSM: NA=1023, write 0x81.
  - `csm_kon` pulses for 1 cycle every 64 cycles.
  - `TM_1` stays 0.
  - Write 0x00: pulses stop.
- Stop/restart and async reset: start A with NA=0 and stop after 1000 cycles.
  - No overflow occurs.
  - Restart with NA=1023: overflow at +64 from the restart.
  - Assert `IC_b` low mid-count (between clock edges): `TM_1`/`TM_2`/`csm_kon` drop to 0 immediately.
  - After release with no LOAD write: no overflow within 70000 cycles.
